// File: rtl/cpu_wb_master_if.sv
// Bundles the CPU request/response handshake and the classic Wishbone master bus.
// The master modport is the bridge's view; the slave modport is the CPU and interconnect side.
interface cpu_wb_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cpu_stb_i;
    logic            cpu_we_i;
    logic [AW-1:0]   cpu_addr_i;
    logic [DW-1:0]   cpu_dat_i;
    logic [DW-1:0]   cpu_dat_o;
    logic            cpu_ready_o;
    logic            bus_err_o;

    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        input  cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_dat_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output cpu_dat_o, cpu_ready_o, bus_err_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    modport slave (
        output cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_dat_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  cpu_dat_o, cpu_ready_o, bus_err_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/cpu_wb_master.sv
// CPU-to-Wishbone bridge: one classic single cycle per core request, one-cycle ready pulse back.
// Define CPU_WB_TIMEOUT_EN to force an error completion after TIMEOUT_CYC unanswered bus cycles.
module cpu_wb_master #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_wb_master_if.master      bus,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic          cyc_q, cyc_n;
    logic          we_q, we_n;
    logic [AW-1:0] adr_q, adr_n;
    logic [DW-1:0] wdat_q, wdat_n;
    logic [DW-1:0] rdat_q, rdat_n;
    logic          ready_q, ready_n;
    logic          err_q, err_n;
    logic          tmo;

`ifdef CPU_WB_TIMEOUT_EN
    localparam int CLOG = $clog2(TIMEOUT_CYC + 1);
    localparam int CW   = (CLOG < 8) ? 8 : CLOG;

    logic [CW-1:0] wait_q, wait_n;

    // Fires on the TIMEOUT_CYC-th BUS edge that would otherwise keep waiting.
    assign tmo = (wait_q == CW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        we_n    = we_q;
        adr_n   = adr_q;
        wdat_n  = wdat_q;
        rdat_n  = rdat_q;
        ready_n = 1'b0;
        err_n   = err_q;
`ifdef CPU_WB_TIMEOUT_EN
        wait_n  = wait_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef CPU_WB_TIMEOUT_EN
                wait_n = '0;
`endif
                if (bus.cpu_stb_i) begin
                    adr_n   = bus.cpu_addr_i;
                    wdat_n  = bus.cpu_dat_i;
                    we_n    = bus.cpu_we_i;
                    cyc_n   = 1'b1;
                    err_n   = 1'b0;
                    state_n = BUS;
                end
            end
            BUS: begin
`ifdef CPU_WB_TIMEOUT_EN
                wait_n = wait_q + 1'b1;
`endif
                // Error (or timeout without ack) wins over data capture.
                if (bus.wb_err_i || (tmo && !bus.wb_ack_i)) begin
                    err_n  = 1'b1;
                    rdat_n = '0;
                end else if (bus.wb_ack_i && !we_q) begin
                    rdat_n = bus.wb_dat_i;
                end
                if (bus.wb_ack_i || bus.wb_err_i || tmo) begin
                    cyc_n   = 1'b0;
                    ready_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                cyc_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cyc_q   <= cyc_n;
            we_q    <= we_n;
            adr_q   <= adr_n;
            wdat_q  <= wdat_n;
            rdat_q  <= rdat_n;
            ready_q <= ready_n;
            err_q   <= err_n;
        end
    end

`ifdef CPU_WB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_n;
        end
    end
`endif

    // Strobe and selects track the cycle flag, so they can never toggle inside a cycle.
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_sel_o    = {(DW/8){cyc_q}};
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = wdat_q;
    assign bus.cpu_dat_o   = rdat_q;
    assign bus.cpu_ready_o = ready_q;
    assign bus.bus_err_o   = err_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cpu_wb_master.sv
// Directed bench for cpu_wb_master: transaction-level model checked every cycle plus literal pins.
module tb_cpu_wb_master;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] state_o;

    cpu_wb_master_if #(.AW(AW), .DW(DW)) bus ();

    cpu_wb_master #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding access, a completion cycle, then idle.
    bit          m_busy, m_done, m_we, m_err, m_tmo;
    logic [31:0] m_adr, m_wdat, m_rdat;
    int          m_wait;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_done = 0; m_we = 0; m_err = 0;
            m_adr = 0; m_wdat = 0; m_rdat = 0; m_wait = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            m_wait++;
            m_tmo = 0;
`ifdef CPU_WB_TIMEOUT_EN
            m_tmo = (m_wait >= TMO);
`endif
            if (bus.wb_ack_i || bus.wb_err_i || m_tmo) begin
                m_busy = 0;
                m_done = 1;
                if (bus.wb_err_i || !bus.wb_ack_i) begin
                    m_err  = 1;
                    m_rdat = 0;
                end else if (!m_we) begin
                    m_rdat = bus.wb_dat_i;
                end
            end
        end else if (bus.cpu_stb_i) begin
            m_busy = 1;
            m_wait = 0;
            m_we   = bus.cpu_we_i;
            m_adr  = bus.cpu_addr_i;
            m_wdat = bus.cpu_dat_i;
            m_err  = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            check("cyc", bus.wb_cyc_o, m_busy);
            check("stb", bus.wb_stb_o, m_busy);
            check("sel", bus.wb_sel_o, m_busy ? 4'hF : 4'h0);
            check("ready", bus.cpu_ready_o, m_done);
            check("state", state_o, m_done ? 2 : (m_busy ? 1 : 0));
            check("cpu_dat", bus.cpu_dat_o, m_rdat);
            check("bus_err", bus.bus_err_o, m_err);
            if (m_busy) begin
                check("adr", bus.wb_adr_o, m_adr);
                check("we", bus.wb_we_o, m_we);
                check("wdat", bus.wb_dat_o, m_wdat);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  n;
    int  rdy_cnt;
    bit  seen;

    initial begin
        bus.cpu_stb_i = 0; bus.cpu_we_i = 0; bus.cpu_addr_i = 0; bus.cpu_dat_i = 0;
        bus.wb_dat_i = 0; bus.wb_ack_i = 0; bus.wb_err_i = 0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cyc", bus.wb_cyc_o, 0);
        check("rst_stb", bus.wb_stb_o, 0);
        check("rst_sel", bus.wb_sel_o, 0);
        check("rst_we", bus.wb_we_o, 0);
        check("rst_adr", bus.wb_adr_o, 0);
        check("rst_wdat", bus.wb_dat_o, 0);
        check("rst_cpu_dat", bus.cpu_dat_o, 0);
        check("rst_ready", bus.cpu_ready_o, 0);
        check("rst_err", bus.bus_err_o, 0);
        check("rst_state", state_o, 0);
        reset = 1;

        // Stray ack/err while idle
        @(negedge clk); bus.wb_ack_i = 1; bus.wb_err_i = 1;
        repeat (2) @(negedge clk);
        bus.wb_ack_i = 0; bus.wb_err_i = 0;
        check("idle_stray_state", state_o, 0);
        check("idle_stray_err", bus.bus_err_o, 0);

        // Read, zero-wait
        @(negedge clk); bus.cpu_stb_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 32'h40; bus.cpu_dat_i = 32'h1111_2222;
        @(posedge clk); #1;
        check("rd_adr", bus.wb_adr_o, 32'h40);
        check("rd_sel", bus.wb_sel_o, 4'hF);
        check("rd_cyc", bus.wb_cyc_o, 1);
        @(negedge clk); bus.cpu_stb_i = 0; bus.cpu_addr_i = 32'hFFFF_FFFF; bus.wb_ack_i = 1; bus.wb_dat_i = 32'h1234_5678;
        @(posedge clk); #1;
        check("rd_ready", bus.cpu_ready_o, 1);
        check("rd_data", bus.cpu_dat_o, 32'h1234_5678);
        check("rd_cyc_drop", bus.wb_cyc_o, 0);
        @(negedge clk); bus.wb_ack_i = 0;
        @(posedge clk); #1;
        check("rd_ready_end", bus.cpu_ready_o, 0);
        check("rd_state_idle", state_o, 0);

        // Write, 3 wait states
        @(negedge clk); bus.cpu_stb_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 32'h100; bus.cpu_dat_i = 32'hCAFE_F00D;
        @(negedge clk); bus.cpu_stb_i = 0; bus.cpu_we_i = 0; bus.cpu_dat_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wr_hold_dat", bus.wb_dat_o, 32'hCAFE_F00D);
            check("wr_hold_we", bus.wb_we_o, 1);
        end
        bus.wb_ack_i = 1;
        @(posedge clk); #1;
        check("wr_ready", bus.cpu_ready_o, 1);
        check("wr_cpu_dat_kept", bus.cpu_dat_o, 32'h1234_5678);
        @(negedge clk); bus.wb_ack_i = 0;
        @(negedge clk);

        // Read with err and ack together
        bus.cpu_stb_i = 1; bus.cpu_addr_i = 32'h200;
        @(negedge clk); bus.cpu_stb_i = 0; bus.wb_ack_i = 1; bus.wb_err_i = 1; bus.wb_dat_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("err_flag", bus.bus_err_o, 1);
        check("err_data", bus.cpu_dat_o, 0);
        check("err_ready", bus.cpu_ready_o, 1);
        @(negedge clk); bus.wb_ack_i = 0; bus.wb_err_i = 0;
        @(negedge clk);

        // Next successful read clears the error
        bus.cpu_stb_i = 1; bus.cpu_addr_i = 32'h44;
        @(posedge clk); #1;
        check("err_clear_on_accept", bus.bus_err_o, 0);
        @(negedge clk); bus.cpu_stb_i = 0; bus.wb_ack_i = 1; bus.wb_dat_i = 32'h55;
        @(posedge clk); #1;
        check("clr_data", bus.cpu_dat_o, 32'h55);
        @(negedge clk); bus.wb_ack_i = 0;
        @(negedge clk);

        // Write ending in error
        bus.cpu_stb_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 32'h104; bus.cpu_dat_i = 32'h9;
        @(negedge clk); bus.cpu_stb_i = 0; bus.cpu_we_i = 0; bus.wb_err_i = 1;
        @(posedge clk); #1;
        check("wr_err_flag", bus.bus_err_o, 1);
        check("wr_err_data", bus.cpu_dat_o, 0);
        @(negedge clk); bus.wb_err_i = 0;
        @(negedge clk);

        // Back-to-back: stb held across DONE, stray ack in IDLE
        bus.cpu_stb_i = 1; bus.cpu_we_i = 0; bus.cpu_addr_i = 32'h80;
        @(negedge clk); bus.wb_ack_i = 1; bus.wb_dat_i = 32'hAAAA_5555;
        @(posedge clk); #1;
        check("b2b_first_ready", bus.cpu_ready_o, 1);
        @(negedge clk); bus.wb_ack_i = 0;
        @(posedge clk); #1;
        check("b2b_done_no_cyc", bus.wb_cyc_o, 0);
        check("b2b_done_idle", state_o, 0);
        @(negedge clk); bus.wb_ack_i = 1; bus.wb_dat_i = 32'hBBBB_0000;
        @(posedge clk); #1;
        check("b2b_second_cyc", bus.wb_cyc_o, 1);
        check("b2b_stray_ignored", bus.cpu_ready_o, 0);
        check("b2b_data_kept", bus.cpu_dat_o, 32'hAAAA_5555);
        @(negedge clk); bus.cpu_stb_i = 0;
        @(posedge clk); #1;
        check("b2b_second_ready", bus.cpu_ready_o, 1);
        check("b2b_second_data", bus.cpu_dat_o, 32'hBBBB_0000);
        @(negedge clk); bus.wb_ack_i = 0;
        @(negedge clk);

        // Reset in the middle of a bus cycle
        bus.cpu_stb_i = 1; bus.cpu_we_i = 1; bus.cpu_addr_i = 32'h300; bus.cpu_dat_i = 32'h77;
        @(negedge clk); bus.cpu_stb_i = 0; bus.cpu_we_i = 0;
        @(negedge clk);
        check("mid_rst_pre_cyc", bus.wb_cyc_o, 1);
        #2 reset = 0;
        #1;
        check("mid_rst_cyc", bus.wb_cyc_o, 0);
        check("mid_rst_stb", bus.wb_stb_o, 0);
        check("mid_rst_ready", bus.cpu_ready_o, 0);
        @(negedge clk); reset = 1;
        repeat (3) @(negedge clk);
        check("mid_rst_state", state_o, 0);

        // Slave never answers
        @(negedge clk); bus.cpu_stb_i = 1; bus.cpu_addr_i = 32'h400;
        @(posedge clk); #1;
        @(negedge clk); bus.cpu_stb_i = 0;
`ifdef CPU_WB_TIMEOUT_EN
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.cpu_ready_o) seen = 1;
        end
        check("tmo_seen", seen, 1);
        check("tmo_edges", n, TMO);
        check("tmo_err", bus.bus_err_o, 1);
        check("tmo_data", bus.cpu_dat_o, 0);
        check("tmo_cyc_drop", bus.wb_cyc_o, 0);
`else
        rdy_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ready_o) rdy_cnt++;
        end
        check("no_tmo_ready", rdy_cnt, 0);
        check("no_tmo_cyc_held", bus.wb_cyc_o, 1);
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
`endif
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
